// File: rtl/pfs32_pipe.sv
// pfs32_pipe: three-stage pipelined Kogge-Stone subtractor, d = a - b - bin.
// Computed as a + ~b + ~bin; bout is the inverted carry out of the MSB.
// Valid/ready on both sides with full back-pressure. Stages can stall one at a time.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready is combinational from out_ready)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid/out_ready   result handshake
//   d, bout               difference and borrow-out (registered)
//   ovf, zero             signed overflow / zero flags (registered)
// Optional feature: define PFS_FLAGS_EN to build the ovf/zero flag logic.
// Without it, ovf and zero are tied to 0.
module pfs32_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int          LVLS  = $clog2(WIDTH);
  localparam int          LVL_A = (LVLS + 1) / 2;
  localparam int unsigned MSB   = WIDTH - 1;

  // Stage valid bits and stall chain.
  logic r1_v, r2_v, r3_v;
  logic w_en1, w_en2, w_en3;

  assign w_en3    = !r3_v | out_ready;
  assign w_en2    = !r2_v | w_en3;
  assign w_en1    = !r1_v | w_en2;
  assign in_ready = w_en1;

  // S1 registers: operands with b inverted and the carry-in derived from bin.
  logic [WIDTH-1:0] r1_a, r1_nb;
  logic             r1_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_a   <= '0;
      r1_nb  <= '0;
      r1_cin <= 1'b0;
    end else if (w_en1) begin
      r1_v   <= in_valid;
      r1_a   <= a;
      r1_nb  <= ~b;
      r1_cin <= ~bin;
    end
  end

  // Bitwise propagate/generate for the S1 operands.
  logic [WIDTH-1:0] w_p0, w_g0;
  assign w_p0 = r1_a ^ r1_nb;
  assign w_g0 = r1_a & r1_nb;

  // First half of the prefix tree. Carry-in is folded into bit 0 generate,
  // so G[i] becomes the carry into bit i+1.
  logic [WIDTH-1:0] w_ga, w_pa;

  always_comb begin : c_tree_a
    logic [WIDTH-1:0] g, p;
    g    = w_g0;
    p    = w_p0;
    g[0] = w_g0[0] | (w_p0[0] & r1_cin);
    for (int k = 0; k < LVL_A; k++) begin
      for (int i = int'(WIDTH) - 1; i >= (1 << k); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << k)]);
        p[i] = p[i] & p[i - (1 << k)];
      end
    end
    w_ga = g;
    w_pa = p;
  end

  // S2 registers: partial group (G,P), bitwise propagate, carry-in.
  logic [WIDTH-1:0] r2_g, r2_p, r2_p0;
  logic             r2_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_g   <= '0;
      r2_p   <= '0;
      r2_p0  <= '0;
      r2_cin <= 1'b0;
    end else if (w_en2) begin
      r2_v   <= r1_v;
      r2_g   <= w_ga;
      r2_p   <= w_pa;
      r2_p0  <= w_p0;
      r2_cin <= r1_cin;
    end
  end

  // Second half of the prefix tree, then the sum and carry out.
  logic [WIDTH-1:0] w_gb, w_carry, w_diff;
  logic             w_cout;

  always_comb begin : c_tree_b
    logic [WIDTH-1:0] g, p;
    g = r2_g;
    p = r2_p;
    for (int k = LVL_A; k < LVLS; k++) begin
      for (int i = int'(WIDTH) - 1; i >= (1 << k); i--) begin
        g[i] = g[i] | (p[i] & g[i - (1 << k)]);
        p[i] = p[i] & p[i - (1 << k)];
      end
    end
    w_gb = g;
  end

  assign w_carry = {w_gb[WIDTH-2:0], r2_cin};
  assign w_diff  = r2_p0 ^ w_carry;
  assign w_cout  = w_gb[MSB];

  // S3 registers drive the outputs directly.
  logic [WIDTH-1:0] r3_d;
  logic             r3_bout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v    <= 1'b0;
      r3_d    <= '0;
      r3_bout <= 1'b0;
    end else if (w_en3) begin
      r3_v    <= r2_v;
      r3_d    <= w_diff;
      r3_bout <= ~w_cout;
    end
  end

  assign out_valid = r3_v;
  assign d         = r3_d;
  assign bout      = r3_bout;

`ifdef PFS_FLAGS_EN
  // Sign bits of a and b travel alongside the tree for the overflow flag.
  logic r2_a_msb, r2_b_msb;
  logic r3_ovf, r3_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_a_msb <= 1'b0;
      r2_b_msb <= 1'b0;
    end else if (w_en2) begin
      r2_a_msb <= r1_a[MSB];
      r2_b_msb <= ~r1_nb[MSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_ovf  <= 1'b0;
      r3_zero <= 1'b0;
    end else if (w_en3) begin
      r3_ovf  <= (r2_a_msb != r2_b_msb) & (w_diff[MSB] != r2_a_msb);
      r3_zero <= ~|w_diff;
    end
  end

  assign ovf  = r3_ovf;
  assign zero = r3_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
